// File: rtl/frame_mem_arbiter.sv
// Burst arbiter sharing one SDRAM command port between the camera write FIFO
// and the display read FIFO, with linear per-frame addressing on each side.
module frame_mem_arbiter #(
    parameter int ADDR_W      = 23,
    parameter int LVL_W       = 10,
    parameter int FIFO_DEPTH  = 512,
    parameter int BURST_LEN   = 8,
    parameter int FRAME_WORDS = 384000,
    parameter int RD_BASE     = 0,
    parameter int WR_BASE     = 0,
    parameter int RD_LOW_WM   = 128,
    parameter int WR_HIGH_WM  = 256
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [LVL_W-1:0]  iRD_LEVEL,
    input  logic [LVL_W-1:0]  iWR_LEVEL,
    input  logic              iRD_FRAME_START,
    input  logic              iWR_FRAME_START,
    output logic              oCMD_VALID,
    input  logic              iCMD_READY,
    output logic              oCMD_WRITE,
    output logic [ADDR_W-1:0] oCMD_ADDR,
    input  logic              iBURST_DONE,
    output logic              oRD_GRANT,
    output logic              oWR_GRANT,
    output logic              oRD_UNDERRUN
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        BUSY = 2'd2
    } state_t;

    localparam logic [LVL_W-1:0] RD_ELIG_MAX = LVL_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [LVL_W-1:0] WR_ELIG_MIN = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] RD_LOW      = LVL_W'(RD_LOW_WM);
    localparam logic [LVL_W-1:0] WR_HIGH     = LVL_W'(WR_HIGH_WM);

    state_t            stateReg, stateNext;
    logic              cmdWriteReg, cmdWriteNext;
    logic [ADDR_W-1:0] cmdAddrReg, cmdAddrNext;
    logic              rrWriteReg, rrWriteNext;
    logic              underrunReg;

    logic              isIdle;
    logic              accept;
    logic [1:0]        acceptSide;
    logic [1:0]        frameStart;
    logic [ADDR_W-1:0] addrEff [2];

    logic rdElig, wrElig, rdUrgent, wrUrgent;
    logic pickWrite;

    assign isIdle     = (stateReg == IDLE);
    assign accept     = (stateReg == CMD) && iCMD_READY;
    assign acceptSide = {accept & cmdWriteReg, accept & ~cmdWriteReg};
    assign frameStart = {iWR_FRAME_START, iRD_FRAME_START};

    // Side 0 is the display read path, side 1 the camera write path.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : sideGen
            localparam int                BASE_I  = (gi == 0) ? RD_BASE : WR_BASE;
            localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_I);
            localparam logic [ADDR_W-1:0] WRAP_AT = ADDR_W'(BASE_I + FRAME_WORDS);

            logic [ADDR_W-1:0] addrReg;
            logic [ADDR_W-1:0] addrInc;
            logic [ADDR_W-1:0] addrStep;
            logic              pendReg;

            assign addrInc  = addrReg + ADDR_W'(BURST_LEN);
            assign addrStep = (addrInc == WRAP_AT) ? BASE : addrInc;

            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    addrReg <= BASE;
                    pendReg <= 1'b0;
                end else begin
                    // A frame start landing on acceptance drops the increment;
                    // the pending flag reloads the base at the next IDLE.
                    if (isIdle && pendReg)
                        addrReg <= BASE;
                    else if (acceptSide[gi] && !frameStart[gi])
                        addrReg <= addrStep;
                    pendReg <= frameStart[gi] | (pendReg & ~isIdle);
                end
            end

            // Arbitration in the same IDLE cycle must already see the base.
            assign addrEff[gi] = pendReg ? BASE : addrReg;
        end
    endgenerate

    assign rdElig   = (iRD_LEVEL <= RD_ELIG_MAX);
    assign wrElig   = (iWR_LEVEL >= WR_ELIG_MIN);
    assign rdUrgent = rdElig && (iRD_LEVEL < RD_LOW);
    assign wrUrgent = wrElig && (iWR_LEVEL >= WR_HIGH);

    always_comb begin
        pickWrite = 1'b0;
        if (rdUrgent)
            pickWrite = 1'b0;
        else if (wrUrgent)
            pickWrite = 1'b1;
        else if (rdElig && wrElig)
            pickWrite = rrWriteReg;
        else
            pickWrite = wrElig;
    end

    always_comb begin
        stateNext    = stateReg;
        cmdWriteNext = cmdWriteReg;
        cmdAddrNext  = cmdAddrReg;
        rrWriteNext  = rrWriteReg;
        case (stateReg)
            IDLE: begin
                if (rdElig || wrElig) begin
                    stateNext    = CMD;
                    cmdWriteNext = pickWrite;
                    cmdAddrNext  = pickWrite ? addrEff[1] : addrEff[0];
                end
            end
            CMD: begin
                if (iCMD_READY) begin
                    stateNext   = BUSY;
                    rrWriteNext = ~cmdWriteReg;
                end
            end
            BUSY: begin
                if (iBURST_DONE)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stateReg    <= IDLE;
            cmdWriteReg <= 1'b0;
            cmdAddrReg  <= '0;
            rrWriteReg  <= 1'b0;
            underrunReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            cmdWriteReg <= cmdWriteNext;
            cmdAddrReg  <= cmdAddrNext;
            rrWriteReg  <= rrWriteNext;
            if ((iRD_LEVEL == '0) && !oRD_GRANT)
                underrunReg <= 1'b1;
        end
    end

    assign oCMD_VALID   = (stateReg == CMD);
    assign oCMD_WRITE   = cmdWriteReg;
    assign oCMD_ADDR    = cmdAddrReg;
    assign oRD_GRANT    = (stateReg == BUSY) && !cmdWriteReg;
    assign oWR_GRANT    = (stateReg == BUSY) && cmdWriteReg;
    assign oRD_UNDERRUN = underrunReg;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter: addressing, wrap, priority,
// round-robin, stall, frame restart and asynchronous reset.
module tb_frame_mem_arbiter;

    localparam int ADDR_W      = 23;
    localparam int LVL_W       = 10;
    localparam int FRAME_WORDS = 2000;
    localparam int RD_BASE     = 0;
    localparam int WR_BASE     = 4096;

    logic              iCLK;
    logic              iRST_N;
    logic [LVL_W-1:0]  iRD_LEVEL;
    logic [LVL_W-1:0]  iWR_LEVEL;
    logic              iRD_FRAME_START;
    logic              iWR_FRAME_START;
    logic              oCMD_VALID;
    logic              iCMD_READY;
    logic              oCMD_WRITE;
    logic [ADDR_W-1:0] oCMD_ADDR;
    logic              iBURST_DONE;
    logic              oRD_GRANT;
    logic              oWR_GRANT;
    logic              oRD_UNDERRUN;

    int assertCount = 0;
    int failCount   = 0;
    int expRd       = RD_BASE;
    int expWr       = WR_BASE;

    frame_mem_arbiter #(
        .FRAME_WORDS (FRAME_WORDS),
        .RD_BASE     (RD_BASE),
        .WR_BASE     (WR_BASE)
    ) dut (
        .iCLK            (iCLK),
        .iRST_N          (iRST_N),
        .iRD_LEVEL       (iRD_LEVEL),
        .iWR_LEVEL       (iWR_LEVEL),
        .iRD_FRAME_START (iRD_FRAME_START),
        .iWR_FRAME_START (iWR_FRAME_START),
        .oCMD_VALID      (oCMD_VALID),
        .iCMD_READY      (iCMD_READY),
        .oCMD_WRITE      (oCMD_WRITE),
        .oCMD_ADDR       (oCMD_ADDR),
        .iBURST_DONE     (iBURST_DONE),
        .oRD_GRANT       (oRD_GRANT),
        .oWR_GRANT       (oWR_GRANT),
        .oRD_UNDERRUN    (oRD_UNDERRUN)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // One complete burst: wait for the command, optionally stall, accept,
    // hold BUSY for 8 cycles, then pulse done. Updates the address model.
    task automatic runBurst(input string tag, input bit expW, input int stall, input bit fsInBusy);
        int          n;
        int          bad;
        logic        w0;
        logic [ADDR_W-1:0] a0;
        n = 0;
        while (oCMD_VALID !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkVal({tag, "_valid"}, 32'(oCMD_VALID), 1);
        w0 = oCMD_WRITE;
        a0 = oCMD_ADDR;
        $display("burst %s dir=%s addr=%0d", tag, w0 ? "WR" : "RD", a0);
        checkVal({tag, "_dir"}, 32'(w0), 32'(expW));
        checkVal({tag, "_addr"}, 32'(a0), expW ? expWr : expRd);
        if (stall > 0) begin
            bad = 0;
            for (int i = 0; i < stall; i++) begin
                tick();
                if (oCMD_VALID !== 1'b1 || oCMD_WRITE !== w0 || oCMD_ADDR !== a0)
                    bad++;
            end
            checkVal({tag, "_stallStable"}, 32'(bad), 0);
            iCMD_READY = 1'b1;
        end
        tick();
        checkVal({tag, "_grant"}, 32'({oRD_GRANT, oWR_GRANT}), expW ? 32'd1 : 32'd2);
        checkVal({tag, "_validDrop"}, 32'(oCMD_VALID), 0);
        if (fsInBusy) begin
            iRD_FRAME_START = 1'b1;
            tick();
            iRD_FRAME_START = 1'b0;
            repeat (6) tick();
        end else begin
            repeat (7) tick();
        end
        iBURST_DONE = 1'b1;
        tick();
        iBURST_DONE = 1'b0;
        checkVal({tag, "_grantEnd"}, 32'({oRD_GRANT, oWR_GRANT}), 0);
        if (expW)
            expWr = ((expWr - WR_BASE + 8) % FRAME_WORDS) + WR_BASE;
        else
            expRd = ((expRd - RD_BASE + 8) % FRAME_WORDS) + RD_BASE;
        if (fsInBusy)
            expRd = RD_BASE;
    endtask

    initial begin
        int n;
        int bad;
        iRST_N          = 1'b0;
        iRD_LEVEL       = '0;
        iWR_LEVEL       = '0;
        iRD_FRAME_START = 1'b0;
        iWR_FRAME_START = 1'b0;
        iCMD_READY      = 1'b1;
        iBURST_DONE     = 1'b0;

        repeat (3) tick();
        checkVal("rst_valid", 32'(oCMD_VALID), 0);
        checkVal("rst_grants", 32'({oRD_GRANT, oWR_GRANT}), 0);
        checkVal("rst_addr", 32'(oCMD_ADDR), 0);
        checkVal("rst_write", 32'(oCMD_WRITE), 0);
        checkVal("rst_underrun", 32'(oRD_UNDERRUN), 0);

        // Release, then one arbitration edge to a valid command.
        iRST_N = 1'b1;
        tick();
        checkVal("firstLatency", 32'(oCMD_VALID), 1);

        // Read-only stream through a full frame wrap, then a restart at 1600.
        for (int k = 0; k <= 450; k++)
            runBurst($sformatf("rd%0d", k), 1'b0, 0, (k == 450));
        checkVal("underrunSet", 32'(oRD_UNDERRUN), 1);
        runBurst("rdRestart", 1'b0, 0, 1'b0);
        runBurst("rdAfterRestart", 1'b0, 0, 1'b0);

        // Urgency: urgent read beats urgent write, then urgent write alone.
        iRD_LEVEL = 10'd100; iWR_LEVEL = 10'd300;
        runBurst("urgRd", 1'b0, 0, 1'b0);
        iRD_LEVEL = 10'd200; iWR_LEVEL = 10'd300;
        runBurst("urgWr", 1'b1, 0, 1'b0);

        // Round-robin between non-urgent eligible sides.
        iRD_LEVEL = 10'd200; iWR_LEVEL = 10'd100;
        runBurst("rr0", 1'b0, 0, 1'b0);
        runBurst("rr1", 1'b1, 0, 1'b0);
        runBurst("rr2", 1'b0, 0, 1'b0);
        runBurst("rr3", 1'b1, 0, 1'b0);

        // Command stall of 20 cycles; following bursts show a single increment.
        iCMD_READY = 1'b0;
        runBurst("stall", 1'b0, 20, 1'b0);
        runBurst("stallNextWr", 1'b1, 0, 1'b0);
        runBurst("stallNextRd", 1'b0, 0, 1'b0);

        // Eligibility boundaries.
        iRD_LEVEL = 10'd505; iWR_LEVEL = 10'd7;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (oCMD_VALID !== 1'b0) bad++;
        end
        checkVal("noneEligible", 32'(bad), 0);
        iRD_LEVEL = 10'd504; iWR_LEVEL = 10'd7;
        runBurst("rdEdge504", 1'b0, 0, 1'b0);
        iRD_LEVEL = 10'd505; iWR_LEVEL = 10'd8;
        runBurst("wrEdge8", 1'b1, 0, 1'b0);
        iRD_LEVEL = 10'd127; iWR_LEVEL = 10'd256;
        runBurst("bothUrgent", 1'b0, 0, 1'b0);
        iRD_LEVEL = 10'd128; iWR_LEVEL = 10'd256;
        runBurst("wrUrgentEdge", 1'b1, 0, 1'b0);

        // Asynchronous reset in the middle of a read burst.
        iRD_LEVEL = 10'd200; iWR_LEVEL = 10'd100;
        n = 0;
        while (oCMD_VALID !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkVal("rstBurst_valid", 32'(oCMD_VALID), 1);
        checkVal("rstBurst_addr", 32'(oCMD_ADDR), expRd);
        tick();
        checkVal("rstBurst_grant", 32'({oRD_GRANT, oWR_GRANT}), 2);
        iRST_N = 1'b0;
        #1;
        checkVal("rstAsync_valid", 32'(oCMD_VALID), 0);
        checkVal("rstAsync_grants", 32'({oRD_GRANT, oWR_GRANT}), 0);
        checkVal("rstAsync_addr", 32'(oCMD_ADDR), 0);
        checkVal("rstAsync_underrun", 32'(oRD_UNDERRUN), 0);
        tick();
        iRST_N = 1'b1;
        expRd = RD_BASE;
        expWr = WR_BASE;
        runBurst("postRstRd", 1'b0, 0, 1'b0);
        runBurst("postRstWr", 1'b1, 0, 1'b0);
        checkVal("underrunStaysClear", 32'(oRD_UNDERRUN), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
